// File: rtl/lines_stats_tracker.sv
// Saturating "lines cleared"/"lines sent" counters with a shared sequential double-dabble
// BCD converter. The converter, FSM and dirty tracking exist only when LINES_STATS_BCD_EN is defined.
module lines_stats_tracker #(
    parameter int MAX_COUNT = 999,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             game_start,
    input  logic             clear_valid,
    input  logic [2:0]       clear_count,
    input  logic             send_valid,
    input  logic [3:0]       send_count,
    output logic [CNT_W-1:0] lines_cleared,
    output logic [CNT_W-1:0] lines_sent,
    output logic [11:0]      lc_bcd,
    output logic [11:0]      ls_bcd,
    output logic             bcd_valid
);

    logic [1:0]            valid_vec;
    logic [1:0][CNT_W:0]   amt_vec;

    assign valid_vec  = {send_valid, clear_valid};
    assign amt_vec[0] = (CNT_W+1)'(clear_count);
    assign amt_vec[1] = (CNT_W+1)'(send_count);

    // Index 0 tracks lines cleared, index 1 tracks lines sent.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W:0]   sum;

        always_comb begin
            sum   = {1'b0, cnt_q} + amt_vec[gi];
            cnt_d = cnt_q;
            if (game_start) begin
                cnt_d = '0;
            end else if (valid_vec[gi]) begin
                cnt_d = (sum > (CNT_W+1)'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : sum[CNT_W-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign lines_cleared = g_cnt[0].cnt_q;
    assign lines_sent    = g_cnt[1].cnt_q;

`ifdef LINES_STATS_BCD_EN

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV_LC,
        ST_CONV_LS
    } state_t;

    localparam int ITER_W = $clog2(CNT_W + 1);

    state_t             state_q, state_d;
    logic               dirty_q, dirty_d;
    logic [CNT_W-1:0]   snap_lc_q, snap_lc_d;
    logic [CNT_W-1:0]   snap_ls_q, snap_ls_d;
    logic [11:0]        work_q, work_d;
    logic [11:0]        lc_res_q, lc_res_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [11:0]        lc_bcd_q, lc_bcd_d;
    logic [11:0]        ls_bcd_q, ls_bcd_d;
    logic               bcd_valid_q, bcd_valid_d;

    logic               event_any;
    logic [11:0]        work_adj;
    logic               shift_bit;
    logic [11:0]        work_step;
    logic               last_step;

    assign event_any = game_start | clear_valid | send_valid;

    for (genvar gi = 0; gi < 3; gi++) begin : g_nib
        assign work_adj[gi*4 +: 4] = (work_q[gi*4 +: 4] >= 4'd5) ? work_q[gi*4 +: 4] + 4'd3
                                                                   : work_q[gi*4 +: 4];
    end

    assign shift_bit = (state_q == ST_CONV_LC) ? snap_lc_q[CNT_W-1] : snap_ls_q[CNT_W-1];
    assign work_step = 12'({work_adj, shift_bit});
    assign last_step = (iter_q == ITER_W'(CNT_W - 1));

    always_comb begin
        state_d     = state_q;
        dirty_d     = dirty_q | event_any;
        snap_lc_d   = snap_lc_q;
        snap_ls_d   = snap_ls_q;
        work_d      = work_q;
        lc_res_d    = lc_res_q;
        iter_d      = iter_q;
        lc_bcd_d    = lc_bcd_q;
        ls_bcd_d    = ls_bcd_q;
        // Registered so it rises one cycle after returning to IDLE; any sampled event drops it at once.
        bcd_valid_d = (state_q == ST_IDLE) && !dirty_q && !event_any;

        case (state_q)
            ST_IDLE: begin
                if (dirty_q) begin
                    snap_lc_d = lines_cleared;
                    snap_ls_d = lines_sent;
                    work_d    = '0;
                    iter_d    = '0;
                    dirty_d   = event_any;
                    state_d   = ST_CONV_LC;
                end
            end
            ST_CONV_LC: begin
                work_d    = work_step;
                snap_lc_d = snap_lc_q << 1;
                iter_d    = iter_q + ITER_W'(1);
                if (last_step) begin
                    lc_res_d = work_step;
                    work_d   = '0;
                    iter_d   = '0;
                    state_d  = ST_CONV_LS;
                end
            end
            ST_CONV_LS: begin
                work_d    = work_step;
                snap_ls_d = snap_ls_q << 1;
                iter_d    = iter_q + ITER_W'(1);
                if (last_step) begin
                    // Both digits land together so the display never mixes old and new values.
                    lc_bcd_d = lc_res_q;
                    ls_bcd_d = work_step;
                    work_d   = '0;
                    iter_d   = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            dirty_q     <= 1'b0;
            snap_lc_q   <= '0;
            snap_ls_q   <= '0;
            work_q      <= '0;
            lc_res_q    <= '0;
            iter_q      <= '0;
            lc_bcd_q    <= '0;
            ls_bcd_q    <= '0;
            bcd_valid_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            dirty_q     <= dirty_d;
            snap_lc_q   <= snap_lc_d;
            snap_ls_q   <= snap_ls_d;
            work_q      <= work_d;
            lc_res_q    <= lc_res_d;
            iter_q      <= iter_d;
            lc_bcd_q    <= lc_bcd_d;
            ls_bcd_q    <= ls_bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign lc_bcd    = lc_bcd_q;
    assign ls_bcd    = ls_bcd_q;
    assign bcd_valid = bcd_valid_q;

`else

    // Display derives decimal digits itself in this build.
    assign lc_bcd    = '0;
    assign ls_bcd    = '0;
    assign bcd_valid = 1'b0;

`endif

endmodule

// File: doc/lines_stats_tracker.md
# lines_stats_tracker

Accumulates the per-game "lines cleared" and "lines sent" statistics from game-logic events and produces the binary counts plus 3-digit BCD forms consumed by the lines display pixel driver. Saturating counters update one cycle after each event. A multi-cycle sequential double-dabble converter builds the BCD digits, so the display path needs no combinational dividers. Sits in the game clock domain between the game FSM (garbage/clear logic) and the display drivers.

## Interface
- MAX_COUNT, 999: saturation ceiling for both counters; must be ≤ 999 and < 2**CNT_W.
- CNT_W, 10: counter width.
- clk  in  1  system clock.
- rst_l  in  1  asynchronous, active-low reset.
- game_start  in  1  pulse; zeroes both counters.
- clear_valid  in  1  one-cycle event: lines cleared by a piece lock.
- clear_count  in  3  lines cleared in the event (0–4 legal).
- send_valid  in  1  one-cycle event: garbage lines sent to opponent.
- send_count  in  4  lines sent in the event (0–10 legal).
- lines_cleared  out  CNT_W  registered cleared count.
- lines_sent  out  CNT_W  registered sent count.
- lc_bcd  out  12  BCD of lines_cleared {hundreds, tens, ones}.
- ls_bcd  out  12  BCD of lines_sent.
- bcd_valid  out  1  1 when lc_bcd/ls_bcd equal the current counter values.

## Operation
- Counter update, per counter independently: game_start → 0; else valid → min(count + amount, MAX_COUNT), sum computed at CNT_W+1 bits; else hold.
- clear_valid and send_valid may be asserted in the same cycle; both counters update.
- game_start has priority over same-cycle valid events; the valid events are dropped.
- Zero-amount events leave the count unchanged, but still set dirty.
- dirty flag: set on any cycle where game_start, clear_valid or send_valid is sampled. Cleared when the FSM snapshots the counters.
- FSM states:
  - IDLE: if dirty, go to CONV_LC; snapshot both counters; clear dirty; load iteration count 0.
  - CONV_LC: one double-dabble step per cycle (add 3 to each nibble ≥ 5, then shift left 1). After CNT_W steps, go to CONV_LS.
  - CONV_LS: same for the sent snapshot, CNT_W steps. On the final step, commit both BCD results to lc_bcd/ls_bcd simultaneously. Then go to IDLE.
- lc_bcd/ls_bcd change only on commit, so the display never sees a half-converted value.
- bcd_valid: forced 0 whenever dirty is set or the FSM is not IDLE. Rises after a commit if no new event arrived during the conversion.
- An event during conversion does not abort it. The stale snapshot still commits, then IDLE re-enters CONV_LC on the next cycle.

## Timing
- Reset values: lines_cleared = 0, lines_sent = 0, lc_bcd = 0, ls_bcd = 0, bcd_valid = 1, FSM = IDLE, dirty = 0.
- Event sampled at edge N:
  - Counters are new after edge N.
  - bcd_valid = 0 after edge N.
  - Snapshot taken at edge N+1.
  - CONV_LC steps occur at edges N+2..N+11; CONV_LS steps at N+12..N+21.
  - Commit at edge N+21; bcd_valid = 1 after edge N+22 (IDLE, no dirty).
- BCD latency is therefore 22 cycles, assuming CNT_W = 10 (2·CNT_W + 2 in general).
- An event arriving every cycle keeps bcd_valid low. Counters remain exact throughout.
- Reset asserted mid-conversion returns every register to its reset value immediately, without waiting for a clock edge.

## Configuration
- LINES_STATS_BCD_EN defined: converter, FSM and dirty logic are present as described.
- LINES_STATS_BCD_EN not defined:
  - Converter, FSM and dirty logic are removed.
  - lc_bcd and ls_bcd are tied to 0; bcd_valid is tied to 0.
  - Counters behave identically.
  - The display falls back to its own binary-to-decimal path.

## Test plan
- Reset, then clear_valid with clear_count = 4 → lines_cleared = 4 one cycle later; bcd_valid falls, returns high 22 cycles after the event sampled with lc_bcd = 12'h004 and ls_bcd = 12'h000.
- send_valid pulses with send_count = 10 repeated 100 times, spaced 30 cycles → lines_sent saturates at 999, not 1000; final ls_bcd = 12'h999.
- clear_valid with count 3 and send_valid with count 2 in the same cycle → lines_cleared = 3 and lines_sent = 2 together; single commit gives lc_bcd = 12'h003 and ls_bcd = 12'h002.
- Second event 5 cycles into a conversion:
  - Stale BCD commits.
  - bcd_valid stays 0.
  - Reconversion starts the next cycle.
  - bcd_valid rises only once the BCD matches the final counts.
- game_start together with clear_valid at counts 57/33 → both counters 0; clear is dropped; BCD becomes 12'h000 for both.
- rst_l low midway through CONV_LS → all outputs at reset values immediately; no commit after release; bcd_valid = 1.
